sd_spi_master: RTL and testbench

SD_SPI_MASTER -- requirements
Module: sd_spi_master

---
 rtl/sd_spi_master.sv | 199 +++++++++++++++++++
 tb/tb_sd_spi_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_master.sv
// SPI-mode SD card master with a CPU-facing data/control register pair.
// Optional macro SD_SPI_LED_STRETCH_EN stretches the activity LED by LED_HOLD clocks.
module sd_spi_master #(
  parameter int DIV_SLOW = 64,
  parameter int DIV_FAST = 2,
  parameter int LED_HOLD = 1048576
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       regSel,
  input  logic [7:0] dataIn,
  output logic [7:0] dataOut,
  input  logic       n_cs,
  input  logic       n_wr,
  input  logic       n_rd,
  output logic       sdCS,
  output logic       sdSCLK,
  output logic       sdMOSI,
  input  logic       sdMISO,
  output logic       driveLED
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  localparam logic [7:0] DIV_SLOW_C = 8'(DIV_SLOW);
  localparam logic [7:0] DIV_FAST_C = 8'(DIV_FAST);

  logic [1:0] state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] bit_q, bit_d;
  logic       done_q, done_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_q, rx_d;
  logic       cs_on_q, cs_on_d;
  logic       fast_q, fast_d;
  logic       overrun_q, overrun_d;
  logic       wr_prev_q, rd_prev_q;

  logic wr_act, rd_act, wr_stb, rd_stb;
  logic busy, start, ctrl_wr, ovr_set, stat_rd, half_end;

  // Strobes count once per assertion: only the first clock of a low pulse qualifies.
  assign wr_act = ~n_cs & ~n_wr;
  assign rd_act = ~n_cs & ~n_rd;
  assign wr_stb = wr_act & ~wr_prev_q;
  assign rd_stb = rd_act & ~rd_prev_q;

  assign busy     = (state_q != ST_IDLE);
  assign start    = wr_stb & ~regSel & ~busy;
  assign ovr_set  = wr_stb & ~regSel & busy;
  assign ctrl_wr  = wr_stb & regSel & ~busy;
  assign stat_rd  = rd_stb & regSel;
  assign half_end = (hcnt_q == div_q - 8'd1);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      wr_prev_q <= wr_act;
      rd_prev_q <= rd_act;
    end
  end

  always_comb begin
    cs_on_d   = cs_on_q;
    fast_d    = fast_q;
    overrun_d = overrun_q;
    if (ctrl_wr) begin
      cs_on_d = dataIn[0];
      fast_d  = dataIn[1];
    end
    // A colliding overrun wins over the clear-on-read.
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (stat_rd) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cs_on_q   <= 1'b0;
      fast_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cs_on_q   <= cs_on_d;
      fast_q    <= fast_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    done_d  = done_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOW;
          div_d   = fast_q ? DIV_FAST_C : DIV_SLOW_C;
          hcnt_d  = 8'd0;
          bit_d   = 3'd0;
          done_d  = 1'b0;
          tx_d    = dataIn;
        end
      end
      ST_LOW: begin
        if (half_end) begin
          state_d = ST_HIGH;
          hcnt_d  = 8'd0;
          rx_sh_d = {rx_sh_q[6:0], sdMISO};
          done_d  = (bit_q == 3'd7);
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (half_end) begin
          hcnt_d = 8'd0;
          if (done_q) begin
            state_d = ST_IDLE;
            rx_d    = rx_sh_q;
          end else begin
            state_d = ST_LOW;
            tx_d    = {tx_q[6:0], 1'b1};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_SLOW_C;
      hcnt_q  <= 8'd0;
      bit_q   <= 3'd0;
      done_q  <= 1'b0;
      tx_q    <= 8'hFF;
      rx_sh_q <= 8'hFF;
      rx_q    <= 8'hFF;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
    end
  end

  assign sdCS    = ~cs_on_q;
  assign sdSCLK  = (state_q == ST_HIGH);
  assign sdMOSI  = busy ? tx_q[7] : 1'b1;
  assign dataOut = regSel ? {busy, overrun_q, 4'b0000, fast_q, cs_on_q} : rx_q;

`ifdef SD_SPI_LED_STRETCH_EN
  localparam int LW = $clog2(LED_HOLD + 2);

  logic [LW-1:0] led_cnt_q;
  logic          led_act;

  assign led_act = busy | cs_on_q;

  // Counter reloads while active, so the LED drops exactly LED_HOLD clocks after the last activity.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      led_cnt_q <= '0;
    end else if (led_act) begin
      led_cnt_q <= LW'(LED_HOLD);
    end else if (led_cnt_q != '0) begin
      led_cnt_q <= led_cnt_q - LW'(1);
    end
  end

  assign driveLED = led_act | (led_cnt_q != '0);
`else
  assign driveLED = cs_on_q;
`endif

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: register access, mode-0 transfers, overrun, reset and LED.
module tb_sd_spi_master;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       regSel;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       n_cs, n_wr, n_rd;
  logic       sdCS, sdSCLK, sdMOSI, sdMISO, driveLED;

  int         tests_run = 0;
  int         fails = 0;
  int         rise_cnt = 0;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] miso_byte = 8'hFF;
  int         miso_base = 0;
  logic [2:0] miso_idx;

  sd_spi_master #(.DIV_SLOW(4), .DIV_FAST(1), .LED_HOLD(10)) dut (
    .clk(clk), .n_reset(n_reset), .regSel(regSel), .dataIn(dataIn), .dataOut(dataOut),
    .n_cs(n_cs), .n_wr(n_wr), .n_rd(n_rd), .sdCS(sdCS), .sdSCLK(sdSCLK),
    .sdMOSI(sdMOSI), .sdMISO(sdMISO), .driveLED(driveLED)
  );

  always #5 clk = ~clk;

  // Slave model: capture MOSI on each SCLK rise, advance MISO to the next bit after it.
  always @(posedge sdSCLK) begin
    rise_cnt <= rise_cnt + 1;
    mosi_cap <= {mosi_cap[6:0], sdMOSI};
  end

  assign miso_idx = 3'(rise_cnt - miso_base);
  assign sdMISO   = miso_byte[3'd7 - miso_idx];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cpu_write(input logic rs, input logic [7:0] d, input int hold);
    @(negedge clk);
    regSel = rs; dataIn = d; n_cs = 1'b0; n_wr = 1'b0;
    repeat (hold) @(negedge clk);
    n_cs = 1'b1; n_wr = 1'b1;
  endtask

  task automatic cpu_read(input logic rs, output logic [7:0] d);
    @(negedge clk);
    regSel = rs; n_cs = 1'b0; n_rd = 1'b0;
    #1 d = dataOut;
    @(negedge clk);
    n_cs = 1'b1; n_rd = 1'b1;
  endtask

  // Runs from a negedge until busy drops; counts busy clocks and the SCLK rise spacing.
  task automatic watch_xfer(output int busy_cyc, output int period);
    int   first, second, n;
    logic prev;
    regSel = 1'b1;
    #1;
    busy_cyc = 0; first = -1; second = -1; prev = sdSCLK;
    for (n = 0; n < 2000; n++) begin
      if (!dataOut[7]) break;
      busy_cyc++;
      if (sdSCLK && !prev) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      prev = sdSCLK;
      @(negedge clk);
    end
    if (n >= 2000) check("xfer_timeout", 32'd1, 32'd0);
    period = second - first;
  endtask

  logic [7:0] v;
  int         bc, per, base, n;

  initial begin
    n_reset = 1'b0; regSel = 1'b0; dataIn = 8'h00;
    n_cs = 1'b1; n_wr = 1'b1; n_rd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sdCS", 32'(sdCS), 32'd1);
    check("rst_sclk", 32'(sdSCLK), 32'd0);
    check("rst_mosi", 32'(sdMOSI), 32'd1);
    check("rst_led", 32'(driveLED), 32'd0);
    n_reset = 1'b1;
    @(negedge clk);
    cpu_read(1'b1, v); check("rst_status", 32'(v), 32'h00);
    cpu_read(1'b0, v); check("rst_data", 32'(v), 32'hFF);

    // Chip select on
    cpu_write(1'b1, 8'h01, 1);
    check("cs_next_clk", 32'(sdCS), 32'd0);
    check("led_cs_on", 32'(driveLED), 32'd1);
    cpu_read(1'b1, v); check("status_cs", 32'(v), 32'h01);

    // Slow transfer 0xA5 out, 0x3C in
    miso_byte = 8'h3C; miso_base = rise_cnt; base = rise_cnt;
    cpu_write(1'b0, 8'hA5, 1);
    watch_xfer(bc, per);
    check("slow_busy", 32'(bc), 32'd64);
    check("slow_rises", 32'(rise_cnt - base), 32'd8);
    check("slow_period", 32'(per), 32'd8);
    check("slow_mosi", 32'(mosi_cap), 32'hA5);
    cpu_read(1'b0, v); check("slow_rx", 32'(v), 32'h3C);
    cpu_read(1'b1, v); check("slow_status", 32'(v), 32'h01);

    // Overrun: second data write and a control write while busy are both ignored
    miso_byte = 8'h00; miso_base = rise_cnt; base = rise_cnt;
    cpu_write(1'b0, 8'h55, 1);
    repeat (4) @(negedge clk);
    cpu_write(1'b0, 8'h33, 1);
    cpu_read(1'b1, v); check("ovr_status", 32'(v), 32'hC1);
    cpu_write(1'b1, 8'h02, 1);
    cpu_read(1'b1, v); check("ovr_cleared", 32'(v), 32'h81);
    watch_xfer(bc, per);
    check("ovr_tx_kept", 32'(mosi_cap), 32'h55);
    check("ovr_rises", 32'(rise_cnt - base), 32'd8);
    cpu_read(1'b1, v); check("ovr_idle_status", 32'(v), 32'h01);
    cpu_read(1'b0, v); check("ovr_rx", 32'(v), 32'h00);

    // Fast transfer
    cpu_write(1'b1, 8'h03, 1);
    cpu_read(1'b1, v); check("fast_status", 32'(v), 32'h03);
    miso_byte = 8'hC3; miso_base = rise_cnt; base = rise_cnt;
    cpu_write(1'b0, 8'hFF, 1);
    watch_xfer(bc, per);
    check("fast_busy", 32'(bc), 32'd16);
    check("fast_period", 32'(per), 32'd2);
    check("fast_rises", 32'(rise_cnt - base), 32'd8);
    cpu_read(1'b0, v); check("fast_rx", 32'(v), 32'hC3);

    // Held write strobe starts one transfer only; LED behaviour with csOn=0
    cpu_write(1'b1, 8'h00, 1);
    miso_byte = 8'h00; miso_base = rise_cnt;
    cpu_write(1'b0, 8'h96, 3);
`ifdef SD_SPI_LED_STRETCH_EN
    check("led_busy", 32'(driveLED), 32'd1);
`else
    check("led_busy", 32'(driveLED), 32'd0);
`endif
    cpu_read(1'b1, v); check("held_wr_status", 32'(v), 32'h80);
    watch_xfer(bc, per);
    check("held_mosi", 32'(mosi_cap), 32'h96);
`ifdef SD_SPI_LED_STRETCH_EN
    n = 0;
    while (driveLED && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("led_hold", 32'(n), 32'd10);
`else
    check("led_tracks_cs", 32'(driveLED), 32'd0);
`endif

    // Reset in the middle of a transfer
    cpu_write(1'b1, 8'h01, 1);
    miso_base = rise_cnt; base = rise_cnt;
    cpu_write(1'b0, 8'h00, 1);
    n = 0;
    while ((rise_cnt - base) < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_rises", 32'(rise_cnt - base), 32'd3);
    check("mid_sclk_high", 32'(sdSCLK), 32'd1);
    n_reset = 1'b0;
    #1;
    check("async_sclk", 32'(sdSCLK), 32'd0);
    check("async_cs", 32'(sdCS), 32'd1);
    check("async_mosi", 32'(sdMOSI), 32'd1);
    check("async_led", 32'(driveLED), 32'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    cpu_read(1'b0, v); check("post_rst_data", 32'(v), 32'hFF);
    cpu_read(1'b1, v); check("post_rst_status", 32'(v), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
